// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers.
//   PIPE_PC_RESET : value a stage's PC registers take while reset is asserted.
//   pipe_state_e  : occupancy of a two-entry (main + skid) stage register. The
//                   encoding is {skid valid, main valid}, so the state register
//                   *is* the pair of valid bits.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] PIPE_PC_RESET = 32'h8000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Fully registered valid/ready pipeline stage with a one-entry skid buffer.
// Outputs come straight from the main entry's registers and in_ready comes
// from the skid entry's valid register, so neither side of the handshake has
// a combinational path through this stage. Sustains one beat per cycle.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   in_valid   : upstream beat present
//   in_ready   : stage can accept a beat (registered)
//   in_data    : upstream payload, DATA_W bits
//   in_pc      : upstream PC
//   out_valid  : beat present downstream (registered)
//   out_ready  : downstream accepts
//   out_data   : downstream payload (registered)
//   out_pc     : downstream PC (registered)
//   flush      : synchronous kill of all held beats
//   cnt_clr    : synchronous clear of stall_cnt
//   stall_cnt  : saturating count of cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 72,
  parameter logic [31:0] PC_RESET = PIPE_PC_RESET,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       st_q, st_d;
  logic              load_m, load_s, m_from_s;
  logic              accept, send;

  logic [DATA_W-1:0] m_data_p1, s_data_p1;
  logic [31:0]       m_pc_p1, s_pc_p1;
  logic [CNT_W-1:0]  stall_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Valids are the state bits: bit0 = main entry, bit1 = skid entry.
  assign out_valid = st_q[0];
  assign in_ready  = ~st_q[1];
  assign out_data  = m_data_p1;
  assign out_pc    = m_pc_p1;
  assign stall_cnt = stall_cnt_q;

  assign accept = in_valid & in_ready;
  assign send   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    load_m   = 1'b0;
    load_s   = 1'b0;
    m_from_s = 1'b0;
    case (st_q)
      EMPTY: begin
        if (accept) begin
          load_m = 1'b1;
          st_d   = ONE;
        end
      end
      ONE: begin
        if (accept && send) begin
          load_m = 1'b1;
        end else if (accept) begin
          load_s = 1'b1;
          st_d   = TWO;
        end else if (send) begin
          st_d   = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so no accept can coincide with the move.
        if (send) begin
          m_from_s = 1'b1;
          st_d     = ONE;
        end
      end
      default: st_d = EMPTY;
    endcase
    // Flush wins over everything, including a same-cycle accept; payload
    // registers keep their contents, only occupancy is dropped.
    if (flush) begin
      st_d     = EMPTY;
      load_m   = 1'b0;
      load_s   = 1'b0;
      m_from_s = 1'b0;
    end
  end

  // ---- stage boundary: main / skid payload registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data_p1 <= '0;
      m_pc_p1   <= PC_RESET;
      s_data_p1 <= '0;
      s_pc_p1   <= PC_RESET;
    end else begin
      if (load_m) begin
        m_data_p1 <= in_data;
        m_pc_p1   <= in_pc;
      end else if (m_from_s) begin
        m_data_p1 <= s_data_p1;
        m_pc_p1   <= s_pc_p1;
      end
      if (load_s) begin
        s_data_p1 <= in_data;
        s_pc_p1   <= in_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 72: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter PC_RESET, default 32'h80000000: reset value of out_pc.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port in_valid, input, 1: upstream beat present.
REQ-007 SHALL have port in_ready, output, 1: stage can accept a beat.
REQ-008 SHALL have port in_data, input, DATA_W: upstream payload (control and data fields).
REQ-009 SHALL have port in_pc, input, 32: upstream PC.
REQ-010 SHALL have port out_valid, output, 1: beat present to downstream.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts.
REQ-012 SHALL have port out_data, output, DATA_W: downstream payload.
REQ-013 SHALL have port out_pc, output, 32: downstream PC.
REQ-014 SHALL have port flush, input, 1: synchronous kill of all held beats.
REQ-015 SHALL have port cnt_clr, input, 1: synchronous clear of stall_cnt.
REQ-016 SHALL have port stall_cnt, output, CNT_W: count of downstream back-pressure cycles.

Function
REQ-017 SHALL hold two entries: main (M) and skid (S), each holding data, pc and valid.
REQ-018 SHALL implement states EMPTY (no entry valid), ONE (M valid), TWO (M and S valid).
REQ-019 SHALL drive out_valid, out_data and out_pc directly from M's registers, with no combinational path from in_* to them.
REQ-020 SHALL drive in_ready = not S.valid from a register, with no combinational path from out_ready.
REQ-021 SHALL define accept = in_valid and in_ready, and send = out_valid and out_ready.
REQ-022 In EMPTY, on accept, SHALL load M from in_* and go to ONE.
REQ-023 In ONE, on accept and send, SHALL load M from in_* and stay in ONE, giving a one-beat-per-cycle throughput.
REQ-024 In ONE, on accept without send, SHALL load S from in_* and go to TWO.
REQ-025 In ONE, on send without accept, SHALL go to EMPTY.
REQ-026 In TWO, on send, SHALL move S into M and go to ONE; otherwise it SHALL hold.
REQ-027 Latency from accept to out_valid SHALL be 1 cycle when the stage was EMPTY or ONE with a send in the same cycle.
REQ-028 Beat order SHALL be preserved, with no beat dropped or duplicated except by flush.
REQ-029 flush SHALL have top priority: the next state is EMPTY, both valids clear, and any beat accepted in the same cycle is discarded.
REQ-030 in_ready SHALL be 1 in the cycle after a flush.
REQ-031 On flush, the data and pc registers SHALL hold their values; only the valids change.
REQ-032 The data and pc registers SHALL load only when their entry is written, holding value otherwise (no toggling on invalid cycles).
REQ-033 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1.
REQ-034 cnt_clr SHALL set stall_cnt to 0 and take priority over increment.
REQ-035 flush SHALL NOT affect stall_cnt.

Reset
REQ-036 While reset=0, the following SHALL hold asynchronously: state EMPTY, out_valid=0, in_ready=1, out_data=0, S data=0, out_pc=PC_RESET, S pc=PC_RESET, stall_cnt=0.
REQ-037 Reset deassertion SHALL take effect at the next rising clk edge, and the first accept is possible in that same cycle.
REQ-038 Reset asserted mid-transfer SHALL discard all held beats, with no partial state retained.

Structure
REQ-039 Shared package pipe_pkg SHALL hold the PC_RESET default constant (32'h80000000) and the state enumeration typedef (EMPTY/ONE/TWO).
REQ-040 The block SHALL be a single module, with no sub-module, and the state SHALL be encoded from the two valid bits.
REQ-041 Successor stage registers (IF/ID through MEM/WB) SHALL instantiate pipe_stage_reg with packed payloads.

Verification
REQ-042 Reset then idle: reset=0 for 3 cycles -> out_valid=0, in_ready=1, out_pc=32'h80000000, stall_cnt=0.
REQ-043 Streaming: out_ready=1, beats 1..8 at in_pc 32'h80000000+4k, one per cycle -> same 8 beats out in order, 1-cycle latency, in_ready constantly 1.
REQ-044 Back-pressure: out_ready=0 after beat A held, send B -> state TWO, in_ready=0, stall_cnt increments each cycle; then out_ready=1 -> A then B out, in_ready returns to 1.
REQ-045 Flush in TWO with in_valid=1 carrying C -> next cycle out_valid=0, in_ready=1, C never appears, stall_cnt unchanged.
REQ-046 Saturation with CNT_W=4: out_ready=0 for 20 cycles with a beat held -> stall_cnt stops at 15; cnt_clr=1 together with a stall -> stall_cnt=0.
REQ-047 Async reset mid-stream, asserted between clock edges -> outputs take reset values immediately, without waiting for a clock edge.
